// File: rtl/top.sv
`timescale 1ns / 1ps
// top -- PS/2 host transmitter with a four-digit seven-segment status display.
//
// On a send request the block inhibits the PS/2 bus, issues a start bit and
// then shifts TX_BYTE out LSB first, followed by odd parity and a stop bit.
// The device generates the clock. The block then samples the device's
// acknowledge bit on the 11th falling clock edge. A watchdog aborts the
// device-clocked phase if it takes too long.
//
// Ports:
//   ck        system clock, all logic on its rising edge
//   reset     synchronous active-high reset
//   ps2_clk   open-drain PS/2 clock (driven 0 or Z only)
//   ps2_data  open-drain PS/2 data  (driven 0 or Z only)
//   send      transmit request, a single-cycle pulse is enough
//   CA..CG    active-low segment cathodes a..g
//   AN        active-low digit anodes: AN0/AN1 show TX_BYTE in hex,
//             AN2 is blank, AN3 shows status ('-', 'A' or 'E')
module top #(
    parameter int unsigned T_INHIBIT = 10000,
    parameter int unsigned T_TIMEOUT = 200000,
    parameter logic [7:0]  TX_BYTE   = 8'hEE,
    parameter int unsigned T_REFRESH = 100000
) (
    input  logic       ck,
    input  logic       reset,
    inout  tri         ps2_clk,
    inout  tri         ps2_data,
    input  logic       send,
    output logic       CA,
    output logic       CB,
    output logic       CC,
    output logic       CD,
    output logic       CE,
    output logic       CF,
    output logic       CG,
    output logic [3:0] AN
);

    localparam int INH_W = $clog2(T_INHIBIT + 1);
    localparam int TO_W  = $clog2(T_TIMEOUT + 1);
    localparam int REF_W = $clog2(T_REFRESH + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(T_INHIBIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(T_TIMEOUT - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(T_REFRESH - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             parity_q, parity_d;
    logic [3:0]       edge_cnt_q, edge_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             ack_ok_q, ack_ok_d;
    logic             error_q, error_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]       digit_q, digit_d;

    // Synchronizer stages; clk_s3 holds the previous synchronized clock value.
    logic clk_s1_q, clk_s1_d;
    logic clk_s2_q, clk_s2_d;
    logic clk_s3_q, clk_s3_d;
    logic dat_s1_q, dat_s1_d;
    logic dat_s2_q, dat_s2_d;

    logic       clk_fall;
    logic       busy;
    logic [6:0] seg;

    // Open-drain pads: only ever pull low or float.
    assign ps2_clk  = clk_oe_q  ? 1'b0 : 1'bz;
    assign ps2_data = data_oe_q ? 1'b0 : 1'bz;

    assign clk_fall = clk_s3_q & ~clk_s2_q;
    assign busy     = (state_q == INHIBIT) || (state_q == START) ||
                      (state_q == SHIFT)   || (state_q == ACK);

    // Active-low segment pattern {a,b,c,d,e,f,g} for one hex digit.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        clk_s1_d = ps2_clk;
        clk_s2_d = clk_s1_q;
        clk_s3_d = clk_s2_q;
        dat_s1_d = ps2_data;
        dat_s2_d = dat_s1_q;
    end

    // Transfer sequencer. The pad enables are computed one state ahead so the
    // line levels are registered together with the state they belong to.
    always_comb begin
        state_d    = state_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        edge_cnt_d = edge_cnt_q;
        inh_cnt_d  = inh_cnt_q;
        to_cnt_d   = to_cnt_q;
        ack_ok_d   = ack_ok_q;
        error_d    = error_q;

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (send) begin
                    shreg_d    = TX_BYTE;
                    parity_d   = ~^TX_BYTE;
                    edge_cnt_d = 4'd0;
                    inh_cnt_d  = '0;
                    ack_ok_d   = 1'b0;
                    error_d    = 1'b0;
                    clk_oe_d   = 1'b1;
                    state_d    = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = START;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            START: begin
                clk_oe_d = 1'b0;
                to_cnt_d = '0;
                state_d  = SHIFT;
            end
            SHIFT, ACK: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (to_cnt_q == TO_LAST) begin
                    error_d   = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = DONE;
                end else if (clk_fall) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (state_q == ACK) begin
                        if (dat_s2_q == 1'b0) begin
                            ack_ok_d = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                        state_d = DONE;
                    end else if (edge_cnt_q < 4'd8) begin
                        // A 1 bit floats high, a 0 bit is pulled low.
                        data_oe_d = ~shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[7:1]};
                    end else if (edge_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end
                end
            end
            DONE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // Display scan: each digit is lit for T_REFRESH cycles in turn.
    always_comb begin
        ref_cnt_d = ref_cnt_q + REF_W'(1);
        digit_d   = digit_q;
        if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            digit_d   = digit_q + 2'd1;
        end
    end

    always_comb begin
        seg = 7'b1111111;
        case (digit_q)
            2'd0: seg = hex_font(TX_BYTE[3:0]);
            2'd1: seg = hex_font(TX_BYTE[7:4]);
            2'd2: seg = 7'b1111111;
            default: begin
                if (busy || (!ack_ok_q && !error_q)) begin
                    seg = 7'b1111110;
                end else if (ack_ok_q) begin
                    seg = 7'b0001000;
                end else begin
                    seg = 7'b0110000;
                end
            end
        endcase
    end

    assign {CA, CB, CC, CD, CE, CF, CG} = seg;
    assign AN = ~(4'b0001 << digit_q);

    always_ff @(posedge ck) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            shreg_q    <= 8'd0;
            parity_q   <= 1'b0;
            edge_cnt_q <= 4'd0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            ack_ok_q   <= 1'b0;
            error_q    <= 1'b0;
            ref_cnt_q  <= '0;
            digit_q    <= 2'd0;
            // Idle bus level is high, so no phantom falling edge after reset.
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_s3_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            edge_cnt_q <= edge_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            ack_ok_q   <= ack_ok_d;
            error_q    <= error_d;
            ref_cnt_q  <= ref_cnt_d;
            digit_q    <= digit_d;
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            clk_s3_q   <= clk_s3_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
        end
    end

endmodule

// File: tb/tb_top.sv
`timescale 1ns / 1ps
// tb_top -- bench for the PS/2 host transmitter and its status display.
// A PS/2 device model drives the clock and optional acknowledge; the display
// is checked from segment-letter descriptions of each expected glyph.
module tb_top;

    localparam int         TI = 20;
    localparam int         TT = 600;
    localparam int         TR = 8;
    localparam logic [7:0] TX = 8'hEE;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic       send = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    wire        ps2_clk;
    wire        ps2_data;
    logic       CA, CB, CC, CD, CE, CF, CG;
    logic [3:0] AN;
    logic [6:0] seg;
    logic [7:0] txv;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] an;
        string      lit;
        string      name;
    } disp_vec_t;

    disp_vec_t vecs[4];

    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_data);

    assign seg = {CA, CB, CC, CD, CE, CF, CG};

    top #(
        .T_INHIBIT(TI),
        .T_TIMEOUT(TT),
        .TX_BYTE  (TX),
        .T_REFRESH(TR)
    ) dut (
        .ck      (ck),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .send    (send),
        .CA      (CA),
        .CB      (CB),
        .CC      (CC),
        .CD      (CD),
        .CE      (CE),
        .CF      (CF),
        .CG      (CG),
        .AN      (AN)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    // Lit segments as letters, e.g. "adefg" for E; converted to active-low a..g.
    function automatic logic [6:0] lit2seg(input string lit);
        logic [6:0] s = 7'h7F;
        for (int i = 0; i < lit.len(); i++) begin
            int k = int'(lit[i]) - 97;
            s[6 - k] = 1'b0;
        end
        return s;
    endfunction

    function automatic string hexLit(input logic [3:0] nib);
        case (nib)
            4'h0: return "abcdef";
            4'h1: return "bc";
            4'h2: return "abdeg";
            4'h3: return "abcdg";
            4'h4: return "bcfg";
            4'h5: return "acdfg";
            4'h6: return "acdefg";
            4'h7: return "abc";
            4'h8: return "abcdefg";
            4'h9: return "abcdfg";
            4'hA: return "abcefg";
            4'hB: return "cdefg";
            4'hC: return "adef";
            4'hD: return "bcdeg";
            4'hE: return "adefg";
            default: return "aefg";
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r);
        send  = s;
        reset = r;
        @(negedge ck);
    endtask

    task automatic waitForAn(input logic [3:0] an, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * TR + 4; i++) begin
            if (AN === an) begin
                ok = 1'b1;
                return;
            end
            @(negedge ck);
        end
    endtask

    task automatic checkDisplay(input string statusLit, input string tag);
        bit ok;
        vecs[3].lit = statusLit;
        for (int i = 0; i < 4; i++) begin
            waitForAn(vecs[i].an, ok);
            if (!ok)
                checkOutput({tag, "_", vecs[i].name, "_an_timeout"}, 32'(AN), 32'(vecs[i].an));
            else
                checkOutput({tag, "_", vecs[i].name}, 32'(seg), 32'(lit2seg(vecs[i].lit)));
        end
    endtask

    task automatic runTransfer(input int nFalls, input bit devAck, input bit pokeSend,
                               input int half, input string tag);
        int         cnt;
        int         shiftStart;
        bit         ok;
        logic [9:0] obs;
        logic [9:0] expBits;
        string      stat;

        for (int i = 0; i < 8; i++) expBits[i] = (txv >> i) & 8'd1;
        expBits[8] = ($countones(txv) % 2 == 0);
        expBits[9] = 1'b1;
        obs = '0;

        applyStimulus(1'b1, 1'b0);
        send = 1'b0;
        cnt = 0;
        while (ps2_clk === 1'b0 && ps2_data === 1'b1 && cnt < TI + 20) begin
            cnt++;
            @(negedge ck);
        end
        checkOutput({tag, "_inhibit_len"}, cnt, TI);
        checkOutput({tag, "_start_bit"}, {30'd0, ps2_clk, ps2_data}, 32'b00);
        @(negedge ck);
        checkOutput({tag, "_clk_release"}, {30'd0, ps2_clk, ps2_data}, 32'b10);
        shiftStart = cyc;

        for (int n = 1; n <= nFalls; n++) begin
            repeat (half) @(negedge ck);
            dev_clk_low = 1'b1;
            if (pokeSend && n == 3) begin
                send = 1'b1;
                @(negedge ck);
                send = 1'b0;
                repeat (half - 2) @(negedge ck);
            end else begin
                repeat (half - 1) @(negedge ck);
            end
            if (n <= 10) obs[n - 1] = ps2_data;
            if (n == 10 && devAck) dev_data_low = 1'b1;
            @(negedge ck);
            dev_clk_low = 1'b0;
        end
        checkOutput({tag, "_bits"}, 32'(obs), 32'(expBits));

        if (nFalls >= 11) begin
            repeat (4) @(negedge ck);
            dev_data_low = 1'b0;
            repeat (4) @(negedge ck);
        end else begin
            dev_data_low = 1'b0;
            while (cyc < shiftStart + TT - 60) @(negedge ck);
            waitForAn(4'b0111, ok);
            checkOutput({tag, "_busy_status"}, ok ? 32'(seg) : 32'hDEAD, 32'(lit2seg("g")));
            while (cyc < shiftStart + TT + 10) @(negedge ck);
        end
        checkOutput({tag, "_lines_idle"}, {30'd0, ps2_clk, ps2_data}, 32'b11);
        stat = (nFalls >= 11 && devAck) ? "abcefg" : "adefg";
        checkDisplay(stat, tag);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  cnt;
        int  lows;
        bit  ok;

        txv = TX;
        vecs[0].an = 4'b1110; vecs[0].lit = hexLit(txv[3:0]); vecs[0].name = "an0";
        vecs[1].an = 4'b1101; vecs[1].lit = hexLit(txv[7:4]); vecs[1].name = "an1";
        vecs[2].an = 4'b1011; vecs[2].lit = "";               vecs[2].name = "an2";
        vecs[3].an = 4'b0111; vecs[3].lit = "g";              vecs[3].name = "an3";

        @(negedge ck);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset_an", 32'(AN), 32'b1110);
        checkOutput("reset_seg", 32'(seg), 32'(lit2seg(hexLit(txv[3:0]))));
        checkOutput("reset_lines", {30'd0, ps2_clk, ps2_data}, 32'b11);

        // send held during reset must not start a transfer
        applyStimulus(1'b0, 1'b0);
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            if (ps2_clk !== 1'b1) lows++;
            @(negedge ck);
        end
        checkOutput("send_in_reset_ignored", lows, 0);
        checkDisplay("g", "post_reset");

        waitForAn(4'b1101, ok);
        cnt = 0;
        while (ok && AN === 4'b1101 && cnt < 2 * TR) begin
            cnt++;
            @(negedge ck);
        end
        checkOutput("refresh_period", cnt, TR);

        runTransfer(11, 1'b1, 1'b0, 10, "ack");
        runTransfer(11, 1'b0, 1'b0, 10, "nack");
        runTransfer(10, 1'b0, 1'b0, 10, "timeout");
        runTransfer(11, 1'b1, 1'b1, 12, "send_in_shift");

        // reset while inhibiting the bus
        applyStimulus(1'b1, 1'b0);
        send = 1'b0;
        repeat (5) @(negedge ck);
        checkOutput("rst_inh_clk_low", {31'd0, ps2_clk}, 32'd0);
        reset = 1'b1;
        @(negedge ck);
        checkOutput("rst_inh_release", {30'd0, ps2_clk, ps2_data}, 32'b11);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < TI + 5; i++) begin
            @(negedge ck);
            if (ps2_clk !== 1'b1) lows++;
        end
        checkOutput("rst_inh_no_restart", lows, 0);
        checkDisplay("g", "rst_inh");

        for (int it = 0; it < 4; it++) begin
            int fallsN;
            bit ackB;
            bit pokeB;
            int halfN;
            fallsN = ($urandom_range(0, 3) == 0) ? 10 : 11;
            ackB   = 1'($urandom_range(0, 1));
            pokeB  = 1'($urandom_range(0, 1));
            halfN  = int'($urandom_range(8, 14));
            runTransfer(fallsN, ackB, pokeB, halfN, $sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter T_INHIBIT, default 10000, is the host clock-inhibit time in ck cycles (100 us at 100 MHz).
REQ-002 Parameter T_TIMEOUT, default 200000, is the ck-cycle limit for the device-clocked phase (2 ms).
REQ-003 Parameter TX_BYTE, default 8'hEE, is the command byte transmitted (PS/2 Echo).
REQ-004 Parameter T_REFRESH, default 100000, is the ck cycles each display digit is lit.
REQ-005 Port ck, input, 1, is the single system clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1, is the synchronous, active-high reset.
REQ-007 Port ps2_clk, inout, 1, is the open-drain PS/2 clock; the block drives only 0 or Z and relies on an external pull-up.
REQ-008 Port ps2_data, inout, 1, is the open-drain PS/2 data line; the block drives only 0 or Z.
REQ-009 Port send, input, 1, is a transmit request; a 1-cycle pulse suffices.
REQ-010 Ports CA, CB, CC, CD, CE, CF, CG, output, 1 each, are the active-low seven-segment cathodes a..g.
REQ-011 Port AN, output, 4, is the active-low digit anodes.

Function
REQ-012 ps2_clk and ps2_data inputs shall each pass through a 2-FF synchronizer; a device falling edge is synchronized previous=1, current=0.
REQ-013 States: IDLE, INHIBIT, START, SHIFT, ACK, DONE.
REQ-014 IDLE: both lines Z. send=1 loads TX_BYTE into the shift register, computes odd parity (~^TX_BYTE, 1 for 0xEE), clears the edge counter, and goes to INHIBIT. send is ignored outside IDLE.
REQ-015 INHIBIT: ps2_clk driven 0 for exactly T_INHIBIT cycles; ps2_data Z.
REQ-016 START: ps2_data driven 0 (start bit) while ps2_clk is still 0 for 1 cycle; then ps2_clk is released to Z and the state goes to SHIFT.
REQ-017 SHIFT: data changes only after synchronized falling edges. Falls 1-8 output data bits 0-7, LSB first; fall 9 outputs parity; fall 10 releases data (stop bit = 1, Z); then go to ACK. A bit value 1 is Z; a bit value 0 is driven low.
REQ-018 ACK: on the 11th synchronized falling edge, sample ps2_data. 0 sets ack_ok; 1 sets error. Then go to DONE.
REQ-019 Timeout counter: cleared on entering SHIFT; if it reaches T_TIMEOUT in SHIFT or ACK, set error, release both lines, and go to DONE.
REQ-020 DONE: lasts 1 cycle with lines Z, then goes to IDLE; the status (ack_ok or error) is held until the next send.
REQ-021 The edge counter is 4 bits wide and counts only in SHIFT and ACK.
REQ-022 The display is multiplexed: one AN bit low at a time, rotating AN0 -> AN1 -> AN2 -> AN3 every T_REFRESH cycles.
REQ-023 AN0 shows hex TX_BYTE[3:0]; AN1 shows hex TX_BYTE[7:4].
REQ-024 AN2 is blank (all segments 1).
REQ-025 AN3 shows status: '-' (only g lit) when idle with no result or when busy; 'A' when ack_ok; 'E' when error.
REQ-026 Hex font: standard 0-F; lowercase b and d are used for B and D.

Reset
REQ-027 While reset=1 at a ck edge: state becomes IDLE, ps2_clk and ps2_data Z, counters 0, ack_ok and error 0, AN=4'b1110, CA..CG show digit 0 value.
REQ-028 Reset mid-transfer shall abort immediately and release both lines the next cycle.
REQ-029 send is ignored while reset=1.

Verification
REQ-030 Reset, then pulse send -> ps2_clk low for T_INHIBIT cycles; then ps2_data low; then ps2_clk released.
REQ-031 Device supplies 11 clock falls (50 us half-period) and drives data 0 after fall 10 -> line sequence at the falls: 0,1,1,1,0,1,1,1 (0xEE LSB first), parity 1, stop Z; status 'A'; state returns to IDLE.
REQ-032 Same as REQ-031 but device never drives the ACK low -> status 'E' after fall 11.
REQ-033 Device gives only 10 falls -> timeout after T_TIMEOUT cycles; status 'E'; both lines Z.
REQ-034 send pulsed during SHIFT -> ignored; the transfer in progress is unchanged.
REQ-035 Reset asserted during INHIBIT -> ps2_clk released the next cycle; status '-'.
